// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus sequencer and response checker for a small combinational gate.
// Each vector is held SETTLE cycles, then the response is compared against TRUTH for one cycle.
module gate_sweep_checker #(
   parameter int unsigned         N_IN   = 2,
   parameter logic [2**N_IN-1:0]  TRUTH  = 4'b1000,
   parameter int unsigned         SETTLE = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [N_IN-1:0] stim,
   input  logic            resp,
   output logic            busy,
   output logic            done,
   output logic            pass,
   output logic [N_IN:0]   err_count,
   output logic            fail_valid,
   output logic [N_IN-1:0] first_fail
);

   localparam int unsigned    CntW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CntW-1:0] CntLast  = CntW'(SETTLE - 1);
   localparam logic [N_IN-1:0] StimLast = {N_IN{1'b1}};

   typedef enum logic [1:0] {StIdle, StHold, StCheck, StDone} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [N_IN-1:0] stim_q, stim_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [N_IN:0]   err_count_q, err_count_d;
   logic            fail_valid_q, fail_valid_d;
   logic [N_IN-1:0] first_fail_q, first_fail_d;
   logic            mismatch;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         stim_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_count_q  <= '0;
         fail_valid_q <= 1'b0;
         first_fail_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         stim_q       <= stim_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
         err_count_q  <= err_count_d;
         fail_valid_q <= fail_valid_d;
         first_fail_q <= first_fail_d;
      end
   end

   assign mismatch = (resp != TRUTH[stim_q]);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      stim_d       = stim_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      err_count_d  = err_count_q;
      fail_valid_d = fail_valid_q;
      first_fail_d = first_fail_q;

      unique case (state_q)
         StIdle, StDone: begin
            // start is only honoured here; a new sweep wipes the previous verdict
            if (start) begin
               state_d      = StHold;
               cnt_d        = '0;
               stim_d       = '0;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               pass_d       = 1'b0;
               err_count_d  = '0;
               fail_valid_d = 1'b0;
               first_fail_d = '0;
            end
         end
         StHold: begin
            if (cnt_q == CntLast) begin
               state_d = StCheck;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StCheck: begin
            err_count_d = err_count_q + {{N_IN{1'b0}}, mismatch};
            if (mismatch && !fail_valid_q) begin
               first_fail_d = stim_q;
               fail_valid_d = 1'b1;
            end
            if (stim_q == StimLast) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               stim_d  = '0;
               pass_d  = (err_count_d == '0);
            end else begin
               state_d = StHold;
               stim_d  = stim_q + 1'b1;
               cnt_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign stim       = stim_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign err_count  = err_count_q;
   assign fail_valid = fail_valid_q;
   assign first_fail = first_fail_q;

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Synthesizable self-test sequencer for small combinational gates. It drives every input combination of a gate under test and samples the gate's response after a settle window. Each response is compared against a parameterised truth table, and the block reports mismatch count, first failing vector and a pass/done verdict. It sits opposite a gate such as the 2-input AND: it generates the stimulus and checks the response.

Parameters:
N_IN, 2, number of gate inputs; sweep covers 2^N_IN vectors; legal 1..8
TRUTH, 4'b1000, expected output per vector; bit i = expected resp when stim == i (default = 2-input AND with stim = {a,b}); width 2^N_IN
SETTLE, 2, cycles each vector is held before sampling; legal >= 1

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  begin a sweep; sampled only in IDLE or DONE
stim  output  N_IN  vector driven to gate under test; stim[N_IN-1] = MSB (a for AND)
resp  input  1  gate under test output
busy  output  1  sweep in progress
done  output  1  sweep complete, results valid; held until next start or reset
pass  output  1  valid when done: 1 iff err_count == 0
err_count  output  N_IN+1  number of mismatching vectors in current/last sweep
fail_valid  output  1  at least one mismatch recorded
first_fail  output  N_IN  index of first mismatching vector; valid when fail_valid

Behaviour:
- Reset (rst_n low at an edge, any state, including mid-sweep): state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0, settle counter=0. Sweep is abandoned and not resumed.
- States: IDLE, HOLD, CHECK, DONE. All outputs registered.
- IDLE/DONE with start=1 at edge: -> HOLD; stim=0, cnt=0, busy=1, done=0, pass=0, err_count=0, fail_valid=0, first_fail=0.
- HOLD: cnt increments each edge; at the edge where cnt == SETTLE-1 -> CHECK. The vector is therefore driven SETTLE cycles in HOLD plus 1 cycle in CHECK.
- CHECK, one edge:
  - sample resp; mismatch when resp != TRUTH[stim].
  - On mismatch: err_count += 1. If fail_valid == 0, first_fail = stim and fail_valid = 1.
  - If stim == 2^N_IN-1 -> DONE, busy=0, done=1, stim=0. pass = 1 iff final err_count (including this vector) == 0.
  - Otherwise stim += 1, cnt=0 -> HOLD.
- Timing: each vector occupies SETTLE+1 cycles. done rises at edge E0 + 2^N_IN*(SETTLE+1), where E0 is the start edge. Defaults give 12 cycles.
- start while busy (HOLD/CHECK): ignored, with no restart and no counter effect.
- DONE: results held stable indefinitely; start=0 keeps DONE. start=1 restarts exactly as from IDLE and clears all results on that edge.
- err_count cannot overflow: max 2^N_IN fits in N_IN+1 bits. stim wrap to 0 occurs only on the DONE transition.
- resp is only sampled in CHECK; resp glitches during HOLD are ignored.

Test Plan:
- Defaults, resp = stim[1]&stim[0] (correct AND), start pulse at E0 -> stim sequence 0,1,2,3 each held 3 cycles; done=1 at E0+12; pass=1, err_count=0, fail_valid=0.
- resp stuck at 0 -> err_count=1, first_fail=3, fail_valid=1, pass=0, done at E0+12.
- resp stuck at 1 -> err_count=3, first_fail=0, pass=0. resp = NAND of inputs -> err_count=4, first_fail=0.
- Correct AND; rst_n low for one edge during vector 2; then start -> all outputs at reset values after the reset edge; new sweep starts at stim=0 and completes with pass=1 after 12 cycles.
- start held high for whole sweep plus extra pulses mid-sweep -> no restart, done at E0+12. start still high in DONE -> immediate restart, done=0 and err_count=0 on the next edge.
- N_IN=3, TRUTH=8'b1001_0110 (XOR3), SETTLE=1, correct XOR3 resp -> 8 vectors of 2 cycles, done at E0+16, pass=1. Flip resp on vector 5 only -> err_count=1, first_fail=5.
